// File: rtl/inst_loader.sv
// Instruction loader: streams program words from an upstream source into a 2^A-deep instruction memory.
// Latency: an accepted beat produces one registered memory write on the following cycle.
// Backpressure: word_ready is high only while loading; words offered outside a session are dropped and flagged.
//
// Ports:
//   clk, reset_n        - single clock, asynchronous active-low reset
//   start               - begin (or restart) a load session from IDLE or DONE
//   word_in/_valid/_last - upstream word stream; _last marks the final program word
//   word_ready          - loader accepts a word this cycle (high in LOAD only)
//   mem_addr/_data/_wren - registered write port to the instruction memory
//   count, checksum     - words written and their modulo-2^N sum for the current/last session
//   done, dropped       - session complete; sticky "word offered while not loading"
module inst_loader #(
  parameter int N = 16,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] word_in,
  input  logic         word_valid,
  input  logic         word_last,
  output logic         word_ready,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_data,
  output logic         mem_wren,
  output logic [A:0]   count,
  output logic [N-1:0] checksum,
  output logic         done,
  output logic         dropped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [A-1:0] ptr;
  logic         accept;
  logic         at_end;

  assign accept = word_valid && word_ready;
  // Last addressable word: the session ends here whether or not word_last is set.
  assign at_end = (ptr == {A{1'b1}});

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // start is deliberately ignored while loading.
        if (accept && (word_last || at_end)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic, decoded from state only
  always_comb begin
    word_ready = 1'b0;
    done       = 1'b0;
    case (state)
      S_LOAD:  word_ready = 1'b1;
      S_DONE:  done       = 1'b1;
      default: begin
        word_ready = 1'b0;
        done       = 1'b0;
      end
    endcase
  end

  // Datapath: write port, pointer, count, checksum, drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      count    <= '0;
      checksum <= '0;
      dropped  <= 1'b0;
    end else begin
      mem_wren <= accept;
      if (state != S_LOAD) begin
        // start wins over a simultaneous word: the session opens clean and the word is discarded.
        if (start) begin
          ptr      <= '0;
          count    <= '0;
          checksum <= '0;
          dropped  <= 1'b0;
        end else if (word_valid) begin
          dropped <= 1'b1;
        end
      end else if (accept) begin
        mem_addr <= ptr;
        mem_data <= word_in;
        // Hold at the top address rather than wrapping; the session is ending anyway.
        if (!at_end) begin
          ptr <= ptr + 1'b1;
        end
        count    <= count + 1'b1;
        checksum <= checksum + word_in;
      end
    end
  end

endmodule
